// File: rtl/dmem_sched_if.sv
// Data-memory scheduler bus bundle.
// Groups the load-unit, store-buffer and memory-port signals of dmem_sched.
//   master : load unit / store buffer / memory side (drives the i_* signals)
//   slave  : the scheduler itself (drives the o_* signals)
// Load unit    : i_ld_req, i_ld_addr, i_ld_kill, o_ld_ack, o_ld_rsp_vld, o_ld_rsp_data
// Store buffer : i_stbuf_pend, i_ret_stbuf, i_ret_stbuf_addr, i_ret_stbuf_data, o_dmem_occupy
// Memory port  : o_dmem_en, o_dmem_we, o_dmem_addr, o_dmem_wdata, i_dmem_rdata
interface dmem_sched_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_ld_req;
    logic [ADDR_W-1:0] i_ld_addr;
    logic              o_ld_ack;
    logic              i_ld_kill;
    logic              o_ld_rsp_vld;
    logic [DATA_W-1:0] o_ld_rsp_data;
    logic              i_stbuf_pend;
    logic              o_dmem_occupy;
    logic              i_ret_stbuf;
    logic [ADDR_W-1:0] i_ret_stbuf_addr;
    logic [DATA_W-1:0] i_ret_stbuf_data;
    logic              o_dmem_en;
    logic              o_dmem_we;
    logic [ADDR_W-1:0] o_dmem_addr;
    logic [DATA_W-1:0] o_dmem_wdata;
    logic [DATA_W-1:0] i_dmem_rdata;

    modport master (
        output i_ld_req, i_ld_addr, i_ld_kill,
        output i_stbuf_pend, i_ret_stbuf, i_ret_stbuf_addr, i_ret_stbuf_data,
        output i_dmem_rdata,
        input  o_ld_ack, o_ld_rsp_vld, o_ld_rsp_data, o_dmem_occupy,
        input  o_dmem_en, o_dmem_we, o_dmem_addr, o_dmem_wdata
    );

    modport slave (
        input  i_ld_req, i_ld_addr, i_ld_kill,
        input  i_stbuf_pend, i_ret_stbuf, i_ret_stbuf_addr, i_ret_stbuf_data,
        input  i_dmem_rdata,
        output o_ld_ack, o_ld_rsp_vld, o_ld_rsp_data, o_dmem_occupy,
        output o_dmem_en, o_dmem_we, o_dmem_addr, o_dmem_wdata
    );
endinterface

// File: rtl/dmem_sched.sv
// Single-port data-memory scheduler: shares the memory port between the load
// unit and store-buffer retirement, sequences fixed-latency reads and keeps a
// continuous load stream from starving committed stores.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : dmem_sched_if.slave (load unit, store buffer and memory port)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | port free; a load may be granted or a store may retire
// LD_WAIT | read in flight; port held busy for LD_LAT-1 more cycles
module dmem_sched #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input logic         clk,
    input logic         rst,
    dmem_sched_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        LD_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] LAT_LOAD  = 4'(LD_LAT - 1);
    localparam logic [3:0] STARVE_TC = 4'(STARVE_MAX);

    state_t            state, state_nxt;
    logic [3:0]        lat_cnt, lat_cnt_nxt;
    logic [3:0]        starve_cnt;
    logic              rd_out, rd_out_nxt;
    logic              kill_flag, kill_flag_nxt;
    logic              starve;
    logic              grant_ld;
    logic              occupy;
    logic              rsp_vld;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rsp_data;

    assign starve = bus.i_stbuf_pend && (starve_cnt == STARVE_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            rd_out    <= 1'b0;
            kill_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            rd_out    <= rd_out_nxt;
            kill_flag <= kill_flag_nxt;
        end
    end

    // Counts cycles a committed store has waited; blocked cycles in LD_WAIT count too.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (bus.i_ret_stbuf || !bus.i_stbuf_pend) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_TC) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // rd_out marks a read issued in an earlier cycle whose data is not yet
    // delivered. Because the port is busy until the response cycle, at most one
    // read is ever outstanding, and the response cycle is the first IDLE cycle
    // with rd_out set. occupy deliberately ignores i_ret_stbuf.
    always_comb begin
        state_nxt     = state;
        lat_cnt_nxt   = lat_cnt;
        rd_out_nxt    = rd_out;
        kill_flag_nxt = kill_flag;
        grant_ld      = 1'b0;
        occupy        = 1'b0;
        case (state)
            IDLE: begin
                grant_ld      = bus.i_ld_req && !starve;
                occupy        = grant_ld;
                rd_out_nxt    = grant_ld;
                kill_flag_nxt = 1'b0;
                if (grant_ld && (LD_LAT >= 2)) begin
                    state_nxt   = LD_WAIT;
                    lat_cnt_nxt = LAT_LOAD;
                end
            end
            LD_WAIT: begin
                occupy        = 1'b1;
                kill_flag_nxt = kill_flag || bus.i_ld_kill;
                lat_cnt_nxt   = lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A kill arriving in the response cycle itself suppresses the response too;
    // a response landing in a reset cycle is dropped.
    always_comb begin
        rsp_vld   = (state == IDLE) && rd_out && !kill_flag && !bus.i_ld_kill && !rst;
        rsp_data  = rsp_vld ? bus.i_dmem_rdata : '0;
        mem_en    = grant_ld || bus.i_ret_stbuf;
        mem_we    = !grant_ld && bus.i_ret_stbuf;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_ld) begin
            mem_addr = bus.i_ld_addr;
        end else if (bus.i_ret_stbuf) begin
            mem_addr  = bus.i_ret_stbuf_addr;
            mem_wdata = bus.i_ret_stbuf_data;
        end
    end

    assign bus.o_ld_ack      = grant_ld;
    assign bus.o_dmem_occupy = occupy;
    assign bus.o_ld_rsp_vld  = rsp_vld;
    assign bus.o_ld_rsp_data = rsp_data;
    assign bus.o_dmem_en     = mem_en;
    assign bus.o_dmem_we     = mem_we;
    assign bus.o_dmem_addr   = mem_addr;
    assign bus.o_dmem_wdata  = mem_wdata;
endmodule

// File: tb/tb_dmem_sched.sv
// Bench for dmem_sched: three instances (LD_LAT = 2, 1, 3; STARVE_MAX = 4),
// each driven by randomized phases and checked against a cycle-level model
// (port-busy horizon, store wait run length, response queue).
module tb_dmem_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        int len;
        int p_ld;
        int p_pend;
        int p_kill;
        bit rst_all;
        bit rst_after;
        bit fixed;
    } phase_t;

    localparam int NPH = 12;

    function automatic phase_t ph(input int i);
        phase_t p;
        p = '{len: 6, p_ld: 0, p_pend: 0, p_kill: 0, rst_all: 1'b0, rst_after: 1'b0, fixed: 1'b0};
        case (i)
            0:  begin p.len = 3; p.rst_all = 1'b1; end
            1:  begin p.len = 4; end
            2:  begin p.len = 1; p.p_ld = 100; p.fixed = 1'b1; end
            3:  begin p.len = 6; end
            4:  begin p.len = 6; p.p_pend = 100; p.fixed = 1'b1; end
            5:  begin p.len = 30; p.p_ld = 100; p.p_pend = 100; end
            6:  begin p.len = 150; p.p_ld = 60; p.p_pend = 40; p.p_kill = 25; end
            7:  begin p.len = 8; end
            8:  begin p.len = 1; p.p_ld = 100; end
            9:  begin p.len = 10; p.rst_after = 1'b1; end
            10: begin p.len = 200; p.p_ld = 50; p.p_pend = 50; p.p_kill = 10; end
            default: begin p.len = 6; end
        endcase
        return p;
    endfunction

    // Memory contents as seen by reads (stores are not reflected).
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A0F0F);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int LAT  = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
        localparam int SMAX = 4;

        logic rst;
        bit   fin = 1'b0;
        dmem_sched_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        dmem_sched #(.ADDR_W(32), .DATA_W(32), .LD_LAT(LAT), .STARVE_MAX(SMAX)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        rsp_t        sb[$];
        logic        rd_vld [16];
        logic [31:0] rd_addr[16];

        initial begin : drive
            int          busy_until;
            int          wait_run;
            int          ri;
            bit          have_ld, st_pend, last_grant, did_rst;
            bit          grant, port_free, starve, exp_occ, ret, rst_now, kill;
            logic [31:0] ld_a, st_a, st_d;
            phase_t      p;
            rsp_t        r;
            string       tag;

            rst                  = 1'b1;
            bus.i_ld_req         = 1'b0;
            bus.i_ld_addr        = '0;
            bus.i_ld_kill        = 1'b0;
            bus.i_stbuf_pend     = 1'b0;
            bus.i_ret_stbuf      = 1'b0;
            bus.i_ret_stbuf_addr = '0;
            bus.i_ret_stbuf_data = '0;
            bus.i_dmem_rdata     = '0;
            for (int i = 0; i < 16; i++) begin
                rd_vld[i]  = 1'b0;
                rd_addr[i] = '0;
            end
            busy_until = 0;
            wait_run   = 0;
            have_ld    = 1'b0;
            st_pend    = 1'b0;
            last_grant = 1'b0;
            ld_a       = '0;
            st_a       = '0;
            st_d       = '0;
            @(posedge clk);

            for (int ph_i = 0; ph_i < NPH; ph_i++) begin
                p       = ph(ph_i);
                did_rst = 1'b0;
                for (int k = 0; k < p.len; k++) begin
                    @(negedge clk);
                    rst_now = p.rst_all || (p.rst_after && last_grant && !did_rst);
                    if (rst_now) begin
                        did_rst = 1'b1;
                        have_ld = 1'b0;
                        st_pend = 1'b0;
                    end else begin
                        if (!have_ld && ($urandom_range(99, 0) < p.p_ld)) begin
                            have_ld = 1'b1;
                            ld_a    = p.fixed ? 32'h100 : (32'($urandom_range(1023, 0)) << 2);
                        end
                        if (!st_pend && ($urandom_range(99, 0) < p.p_pend)) begin
                            st_pend = 1'b1;
                            st_a    = p.fixed ? 32'h40 : ($urandom & 32'h0000FFFC);
                            st_d    = p.fixed ? 32'h5 : $urandom;
                        end
                    end

                    port_free = (cyc >= busy_until);
                    starve    = st_pend && (wait_run >= SMAX);
                    grant     = port_free && have_ld && !starve;
                    exp_occ   = !port_free || grant;
                    ret       = st_pend && !exp_occ;
                    kill      = !rst_now && !grant && ($urandom_range(99, 0) < p.p_kill);

                    ri                   = (cyc - LAT) & 15;
                    rst                  = rst_now;
                    bus.i_ld_req         = have_ld;
                    bus.i_ld_addr        = ld_a;
                    bus.i_ld_kill        = kill;
                    bus.i_stbuf_pend     = st_pend;
                    bus.i_ret_stbuf      = ret;
                    bus.i_ret_stbuf_addr = st_a;
                    bus.i_ret_stbuf_data = st_d;
                    bus.i_dmem_rdata     = rd_vld[ri] ? mem_val(rd_addr[ri]) : $urandom;

                    #2;
                    tag = $sformatf("lat%0d_c%0d", LAT, cyc);
                    chk({tag, "_ack"}, 32'(bus.o_ld_ack), 32'(grant));
                    chk({tag, "_occupy"}, 32'(bus.o_dmem_occupy), 32'(exp_occ));
                    chk({tag, "_en"}, 32'(bus.o_dmem_en), 32'(grant || ret));
                    chk({tag, "_we"}, 32'(bus.o_dmem_we), 32'(!grant && ret));
                    chk({tag, "_no_collision"}, 32'(bus.i_ret_stbuf && bus.o_dmem_occupy), 32'd0);
                    if (grant) chk({tag, "_rd_addr"}, bus.o_dmem_addr, ld_a);
                    if (!grant && ret) begin
                        chk({tag, "_wr_addr"}, bus.o_dmem_addr, st_a);
                        chk({tag, "_wr_data"}, bus.o_dmem_wdata, st_d);
                    end
                    if (ph_i == 1) begin
                        chk({tag, "_idle_addr"}, bus.o_dmem_addr, 32'd0);
                        chk({tag, "_idle_wdata"}, bus.o_dmem_wdata, 32'd0);
                    end

                    rd_vld[cyc & 15]  = bus.o_dmem_en && !bus.o_dmem_we;
                    rd_addr[cyc & 15] = bus.o_dmem_addr;

                    if (kill) begin
                        for (int q = sb.size() - 1; q >= 0; q--) begin
                            if ((sb[q].due - LAT < cyc) && (sb[q].due >= cyc)) sb.delete(q);
                        end
                    end
                    if (grant) begin
                        busy_until = cyc + LAT;
                        r.due      = cyc + LAT;
                        r.data     = mem_val(ld_a);
                        sb.push_back(r);
                        have_ld    = 1'b0;
                    end
                    if (ret || !st_pend) wait_run = 0;
                    else if (wait_run < SMAX) wait_run = wait_run + 1;
                    if (ret) st_pend = 1'b0;
                    if (rst_now) begin
                        busy_until = 0;
                        wait_run   = 0;
                        sb.delete();
                    end
                    last_grant = grant;
                end
            end
            @(negedge clk);
            #4;
            chk($sformatf("lat%0d_drained", LAT), 32'(sb.size()), 32'd0);
            fin = 1'b1;
        end

        initial begin : monitor
            bit   exp_v;
            rsp_t e;
            forever begin
                @(negedge clk);
                #3;
                exp_v = (sb.size() > 0) && (sb[0].due == cyc);
                chk($sformatf("lat%0d_c%0d_rsp_vld", LAT, cyc), 32'(bus.o_ld_rsp_vld), 32'(exp_v));
                if (exp_v) begin
                    e = sb.pop_front();
                    if (bus.o_ld_rsp_vld === 1'b1)
                        chk($sformatf("lat%0d_c%0d_rsp_data", LAT, cyc), bus.o_ld_rsp_data, e.data);
                end
                while ((sb.size() > 0) && (sb[0].due < cyc)) void'(sb.pop_front());
            end
        end
    end

    initial begin : finish_ctl
        int guard;
        guard = 0;
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && (guard < 5000)) begin
            @(posedge clk);
            guard++;
        end
        checks++;
        if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
            failures++;
            $display("FAIL run_timeout actual=unfinished required=finished");
        end
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
